// File: rtl/vec_addsub_stream.sv
// -----------------------------------------------------------------------------
// vec_addsub_stream
//
// Streams a vector of `vlen` beats through a single registered ALU stage.
// Each beat carries LANES elements of WIDTH bits; lane i occupies
// bits [i*WIDTH +: WIDTH]. Four operations are supported: wrapping add,
// wrapping subtract (a-b), signed saturating add and signed saturating
// subtract. Operation and length are latched on an honoured start. A
// sticky per-lane signed-overflow flag is kept for the whole vector.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   start      begin a vector op (honoured only while busy=0)
//   op         00 add, 01 sub, 10 sat add, 11 sat sub (latched on start)
//   vlen       vector length in beats (latched on start)
//   busy       high while a vector is running or draining
//   done       one-cycle pulse after the final beat leaves
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid & in_ready
//   in_a/in_b  operand lanes
//   out_valid  result beat valid
//   out_ready  downstream accepts when out_valid & out_ready
//   out_res    result lanes
//   out_last   high with the final beat of the vector
//   ovf        sticky signed-overflow flag per lane, cleared on start
// -----------------------------------------------------------------------------
module vec_addsub_stream #(
    parameter int LANES = 4,
    parameter int WIDTH = 8,
    parameter int VL_W  = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [VL_W-1:0]        vlen,
    output logic                   busy,
    output logic                   done,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_res,
    output logic                   out_last,
    output logic [LANES-1:0]       ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_SADD = 2'b10,
        OP_SSUB = 2'b11
    } op_t;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                 state;
    state_t                 state_nxt;
    op_t                    op_q;
    logic [VL_W-1:0]        vlen_q;
    logic [VL_W-1:0]        in_cnt;

    logic                   start_ok;
    logic                   accept;
    logic                   out_hs;
    logic                   last_in;
    logic [LANES*WIDTH-1:0] alu_res;
    logic [LANES-1:0]       alu_ovf;

    // One lane: returns {overflow, result}. Overflow is the two's-complement
    // condition; direction of saturation follows the sign of a, since an
    // overflow can only push the result away from a's side of zero.
    function automatic logic [WIDTH:0] lane_alu(
        input op_t              f,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic             is_sub;
        logic             is_sat;
        logic             of;
        logic [WIDTH-1:0] r;
        is_sub = (f == OP_SUB)  || (f == OP_SSUB);
        is_sat = (f == OP_SADD) || (f == OP_SSUB);
        r      = is_sub ? (a - b) : (a + b);
        of     = (is_sub ? (a[WIDTH-1] != b[WIDTH-1]) : (a[WIDTH-1] == b[WIDTH-1]))
                 && (r[WIDTH-1] != a[WIDTH-1]);
        if (is_sat && of) begin
            r = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
        return {of, r};
    endfunction

    assign start_ok = start && (state == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign last_in  = (in_cnt == vlen_q - VL_W'(1));

    // ---------------------------------------------------------------- ALU ---
    always_comb begin
        logic [WIDTH:0] lane;
        // NOTE: every variable gets a default before any branch or loop so
        // the block stays purely combinational and no latch is inferred.
        lane    = '0;
        alu_res = '0;
        alu_ovf = '0;
        for (int i = 0; i < LANES; i++) begin
            lane                      = lane_alu(op_q, in_a[i*WIDTH +: WIDTH], in_b[i*WIDTH +: WIDTH]);
            alu_res[i*WIDTH +: WIDTH] = lane[WIDTH-1:0];
            alu_ovf[i]                = lane[WIDTH];
        end
    end

    // ------------------------------------------------- FSM: state register ---
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------- FSM: next state ---
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start && (vlen != '0)) state_nxt = S_RUN;
            S_RUN:   if (accept && last_in)     state_nxt = S_DRAIN;
            S_DRAIN: if (out_hs && out_last)    state_nxt = S_IDLE;
            default:                            state_nxt = S_IDLE;
        endcase
    end

    // --------------------------------------------------------- FSM: outputs ---
    // in_ready deliberately ignores in_valid: it only reflects whether the
    // output register is free (or being emptied on this edge).
    always_comb begin
        busy     = (state != S_IDLE);
        in_ready = (state == S_RUN) && (!out_valid || out_ready);
    end

    // ------------------------------------------------------------ datapath ---
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset too, so out_res, ovf and the
        // counters read as zero during reset and in-flight beats are dropped.
        if (!rst_n) begin
            op_q      <= OP_ADD;
            vlen_q    <= '0;
            in_cnt    <= '0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_last  <= 1'b0;
            ovf       <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            // start_ok (IDLE) and accept (RUN) are mutually exclusive.
            if (start_ok) begin
                op_q   <= op_t'(op);
                vlen_q <= vlen;
                in_cnt <= '0;
                ovf    <= '0;
                if (vlen == '0) begin
                    done <= 1'b1;
                end
            end

            if (accept) begin
                out_res  <= alu_res;
                out_last <= last_in;
                ovf      <= ovf | alu_ovf;
                in_cnt   <= in_cnt + VL_W'(1);
            end

            // A new beat refills the register on the same edge it empties.
            if (accept) begin
                out_valid <= 1'b1;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end

            if ((state == S_DRAIN) && out_hs && out_last) begin
                done <= 1'b1;
            end
        end
    end

endmodule
